// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes ALU control fields into a 5-bit op code and issues
// it through a valid/ready handshake. Single-cycle ops are held for the
// consumer. RV32M multiply/divide ops stall for a parameterised latency first.
module alu_issue_ctrl #(
  parameter int ENABLE_M    = 1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_control,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] alu_con_out,
  output logic       illegal,
  output logic       busy
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_XOR  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b01001;
  localparam logic [4:0] OP_SRL  = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01011;
  localparam logic [4:0] OP_SLTU = 5'b01100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // The counter holds "edges left minus one", so a latency L loads L-1.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    STALL = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] op_q, op_d;
  logic       ill_q, ill_d;

  logic [4:0] dec_op;
  logic       dec_ill;
  logic [5:0] dec_load;
  logic       dec_long;
  logic       accept;

  // Shared funct3 table used by both R-type (funct7 = 0) and I-type ops.
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] r;
    case (f3)
      3'b000:  r = OP_ADD;
      3'b001:  r = OP_SLL;
      3'b010:  r = OP_SLT;
      3'b011:  r = OP_SLTU;
      3'b100:  r = OP_XOR;
      3'b101:  r = OP_SRL;
      3'b110:  r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  // Combinational decode of the incoming request; illegal ops fall back to ADD.
  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    case (alu_control)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (func7 == F7_BASE) begin
          dec_op = base_op(func3);
        end else if (func7 == F7_ALT) begin
          if (func3 == 3'b000)      dec_op  = OP_SUB;
          else if (func3 == 3'b101) dec_op  = OP_SRA;
          else                      dec_ill = 1'b1;
        end else if (func7 == F7_MEXT) begin
          if (ENABLE_M != 0) dec_op  = {2'b10, func3};
          else               dec_ill = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: begin
        if (func3 == 3'b001) begin
          if (func7 == F7_BASE) dec_op  = OP_SLL;
          else                  dec_ill = 1'b1;
        end else if (func3 == 3'b101) begin
          if (func7 == F7_BASE)     dec_op  = OP_SRL;
          else if (func7 == F7_ALT) dec_op  = OP_SRA;
          else                      dec_ill = 1'b1;
        end else begin
          dec_op = base_op(func3);
        end
      end
    endcase
    if (dec_ill) dec_op = OP_ADD;
  end

  // Only legal M-ops (bit 4 set) can be multi-cycle; funct3[2] selects div/rem.
  assign dec_load = dec_op[2] ? DIV_LOAD : MUL_LOAD;
  assign dec_long = ~dec_ill & dec_op[4] & (dec_load != 6'd0);

  assign in_ready    = ~flush & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  assign accept      = in_valid & in_ready;
  assign out_valid   = (state_q == HOLD);
  assign busy        = (state_q == STALL);
  assign alu_con_out = op_q;
  assign illegal     = ill_q;

  // Next-state logic: flush wins, then countdown/handshake, then a new accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        STALL: begin
          if (cnt_q <= 6'd1) begin
            state_d = HOLD;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = state_q;
      endcase
      if (accept) begin
        op_d  = dec_op;
        ill_d = dec_ill;
        if (dec_long) begin
          state_d = STALL;
          cnt_d   = dec_load;
        end else begin
          state_d = HOLD;
          cnt_d   = 6'd0;
        end
      end
    end
  end

  // State, counter and held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 5'b00000;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: two instances (M extension on and off) share
// one stimulus stream and are compared against a transaction-level model
// that tracks the cycle each pending result becomes visible.
module tb_alu_issue_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] alu_control = 2'b00;
  logic [2:0] func3 = 3'b000;
  logic [6:0] func7 = 7'b0000000;
  logic       out_ready = 1'b0;

  logic       rdy [2];
  logic       ov  [2];
  logic       bz  [2];
  logic       ill [2];
  logic [4:0] op  [2];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit         m_have [2];
  int         m_due  [2];
  logic [4:0] m_op   [2];
  logic       m_ill  [2];

  logic [4:0] r_tbl [8];
  logic       s_rdy, s_ov, s_bz, s_ill, s_ill_n, s_ov_n;
  logic [4:0] s_op, s_op_n;

  alu_issue_ctrl #(.ENABLE_M(1), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .alu_control(alu_control), .func3(func3), .func7(func7), .out_valid(ov[0]),
    .out_ready(out_ready), .alu_con_out(op[0]), .illegal(ill[0]), .busy(bz[0])
  );

  alu_issue_ctrl #(.ENABLE_M(0), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .alu_control(alu_control), .func3(func3), .func7(func7), .out_valid(ov[1]),
    .out_ready(out_ready), .alu_con_out(op[1]), .illegal(ill[1]), .busy(bz[1])
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode taken straight from the op tables; latency 1 unless legal M-op.
  task automatic ref_decode(input bit en_m, output logic [4:0] o, output logic il, output int lat);
    o = 5'b00010; il = 1'b0; lat = 1;
    if (alu_control == 2'd0) o = 5'b00010;
    else if (alu_control == 2'd1) o = 5'b00110;
    else if (alu_control == 2'd2) begin
      if (func7 == 7'h00) o = r_tbl[func3];
      else if (func7 == 7'h20) begin
        if (func3 == 3'd0) o = 5'b00110;
        else if (func3 == 3'd5) o = 5'b01011;
        else il = 1'b1;
      end else if (func7 == 7'h01 && en_m) begin
        o = {2'b10, func3};
        lat = (func3 >= 3'd4) ? DIV_LAT : MUL_LAT;
      end else il = 1'b1;
    end else begin
      if (func3 == 3'd1 && func7 != 7'h00) il = 1'b1;
      else if (func3 == 3'd5) begin
        if (func7 == 7'h00) o = 5'b01010;
        else if (func7 == 7'h20) o = 5'b01011;
        else il = 1'b1;
      end else o = r_tbl[func3];
    end
    if (il) begin o = 5'b00010; lat = 1; end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] ac, input logic [2:0] f3,
                               input logic [6:0] f7, input logic ordy, input logic fl);
    in_valid = v; alu_control = ac; func3 = f3; func7 = f7; out_ready = ordy; flush = fl;
  endtask

  // Compares every instance against the model for the current cycle.
  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      bit ev, eb, er;
      ev = m_have[i] && (cyc >= m_due[i]);
      eb = m_have[i] && (cyc < m_due[i]);
      er = !flush && (!m_have[i] || (ev && out_ready));
      chk($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(er));
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(ev));
      chk($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(eb));
      if (ev) begin
        chk($sformatf("alu_con_out[%0d]", i), 32'(op[i]), 32'(m_op[i]));
        chk($sformatf("illegal[%0d]", i), 32'(ill[i]), 32'(m_ill[i]));
      end
    end
    s_rdy = rdy[0]; s_ov = ov[0]; s_bz = bz[0]; s_op = op[0]; s_ill = ill[0];
    s_ov_n = ov[1]; s_op_n = op[1]; s_ill_n = ill[1];
  endtask

  // Model update for the coming rising edge, using pre-edge inputs.
  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      bit ev, er;
      logic [4:0] o; logic il; int lat;
      ev = m_have[i] && (cyc >= m_due[i]);
      er = !flush && (!m_have[i] || (ev && out_ready));
      if (flush) m_have[i] = 1'b0;
      else begin
        if (ev && out_ready) m_have[i] = 1'b0;
        if (in_valid && er) begin
          ref_decode(i == 0, o, il, lat);
          m_have[i] = 1'b1; m_due[i] = cyc + lat; m_op[i] = o; m_ill[i] = il;
        end
      end
    end
  endtask

  task automatic cycle_once();
    @(negedge clk);
    checkOutput();
    modelEdge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyReset();
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 0, 0);
    rst = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst out_valid[%0d]", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst busy[%0d]", i), 32'(bz[i]), 32'd0);
      chk($sformatf("rst alu_con_out[%0d]", i), 32'(op[i]), 32'd0);
      chk($sformatf("rst illegal[%0d]", i), 32'(ill[i]), 32'd0);
      m_have[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [2:0] f3s [3];
    logic [4:0] exps [3];
    int k, nb;
    r_tbl[0] = 5'b00010; r_tbl[1] = 5'b01001; r_tbl[2] = 5'b00111; r_tbl[3] = 5'b01100;
    r_tbl[4] = 5'b01000; r_tbl[5] = 5'b01010; r_tbl[6] = 5'b00001; r_tbl[7] = 5'b00000;
    for (int i = 0; i < 2; i++) begin m_have[i] = 0; m_due[i] = 0; m_op[i] = 0; m_ill[i] = 0; end

    applyReset();
    cycle_once();
    chk("first in_ready after reset", 32'(s_rdy), 32'd1);

    // R-type SUB, result next cycle
    applyStimulus(1, 2'b10, 3'b000, 7'h20, 1, 0);
    cycle_once();
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 0);
    cycle_once();
    chk("sub out_valid", 32'(s_ov), 32'd1);
    chk("sub op", 32'(s_op), 32'h06);
    chk("sub illegal", 32'(s_ill), 32'd0);

    // Back-to-back I-type AND, OR, SLTU
    f3s[0] = 3'b111; f3s[1] = 3'b110; f3s[2] = 3'b011;
    exps[0] = 5'b00000; exps[1] = 5'b00001; exps[2] = 5'b01100;
    for (int j = 0; j < 4; j++) begin
      applyStimulus(j < 3, 2'b11, (j < 3) ? f3s[j] : 3'd0, 7'h00, 1, 0);
      cycle_once();
      if (j < 3) chk($sformatf("b2b in_ready %0d", j), 32'(s_rdy), 32'd1);
      if (j > 0) begin
        chk($sformatf("b2b out_valid %0d", j), 32'(s_ov), 32'd1);
        chk($sformatf("b2b op %0d", j), 32'(s_op), 32'(exps[j-1]));
      end
    end

    // DIV latency and busy duration
    applyStimulus(1, 2'b10, 3'b100, 7'h01, 1, 0);
    cycle_once();
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 0);
    k = 0; nb = 0;
    while (k < 40) begin
      k++;
      cycle_once();
      if (s_bz) nb++;
      if (s_ov) break;
    end
    chk("div latency", 32'(k), 32'd32);
    chk("div busy cycles", 32'(nb), 32'd31);
    chk("div op", 32'(s_op), 32'h14);
    cycle_once();

    // M-op with ENABLE_M=0 is illegal, then I-type SLL with bad funct7
    applyStimulus(1, 2'b10, 3'b100, 7'h01, 1, 0);
    cycle_once();
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 0);
    cycle_once();
    chk("nom out_valid", 32'(s_ov_n), 32'd1);
    chk("nom op", 32'(s_op_n), 32'h02);
    chk("nom illegal", 32'(s_ill_n), 32'd1);
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 1);
    cycle_once();
    applyStimulus(1, 2'b11, 3'b001, 7'h20, 1, 0);
    cycle_once();
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 0);
    cycle_once();
    chk("islli illegal", 32'(s_ill), 32'd1);
    chk("islli op", 32'(s_op), 32'h02);

    // Consumer stalls for 5 cycles while new requests are offered
    applyStimulus(1, 2'b00, 3'd0, 7'h00, 0, 0);
    cycle_once();
    applyStimulus(1, 2'b01, 3'd0, 7'h00, 0, 0);
    for (int j = 0; j < 5; j++) begin
      cycle_once();
      chk($sformatf("stall in_ready %0d", j), 32'(s_rdy), 32'd0);
      chk($sformatf("stall op %0d", j), 32'(s_op), 32'h02);
    end
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 0);
    cycle_once();
    cycle_once();

    // Flush at cycle 10 of a DIV
    applyStimulus(1, 2'b10, 3'b101, 7'h01, 1, 0);
    cycle_once();
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 0);
    for (int j = 0; j < 9; j++) cycle_once();
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 1);
    cycle_once();
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 0);
    cycle_once();
    chk("flush busy", 32'(s_bz), 32'd0);
    chk("flush in_ready", 32'(s_rdy), 32'd1);
    for (int j = 0; j < 35; j++) cycle_once();

    // Reset in the middle of a DIV stall
    applyStimulus(1, 2'b10, 3'b110, 7'h01, 1, 0);
    cycle_once();
    applyStimulus(0, 2'b00, 3'd0, 7'h00, 1, 0);
    for (int j = 0; j < 5; j++) cycle_once();
    applyReset();
    cycle_once();
    chk("rst-stall busy", 32'(s_bz), 32'd0);
    chk("rst-stall in_ready", 32'(s_rdy), 32'd1);
    for (int j = 0; j < 35; j++) cycle_once();

    // Randomized traffic
    for (int j = 0; j < 500; j++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 5))
        0, 4:    f7 = 7'h00;
        1:       f7 = 7'h20;
        2, 5:    f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), f7,
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
      if ($urandom_range(0, 250) == 0) applyReset();
      else cycle_once();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter ENABLE_M, default 1; 1 decodes RV32M ops, 0 flags them illegal.
REQ-002 SHALL have parameter MUL_LATENCY, default 2; cycles from accept to out_valid for MUL* ops, legal range 1..15.
REQ-003 SHALL have parameter DIV_LATENCY, default 32; cycles from accept to out_valid for DIV*/REM* ops, legal range 1..63.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port flush  input  1  synchronous discard of in-flight or held op.
REQ-007 SHALL have port in_valid  input  1  request valid.
REQ-008 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-009 SHALL have port alu_control  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-010 SHALL have port func3  input  3  instruction funct3.
REQ-011 SHALL have port func7  input  7  instruction funct7.
REQ-012 SHALL have port out_valid  output  1  registered result valid.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port alu_con_out  output  5  ALU op code.
REQ-015 SHALL have port illegal  output  1  decoded op is illegal; qualified by out_valid.
REQ-016 SHALL have port busy  output  1  high while a multi-cycle op is counting.

Function
REQ-017 SHALL encode ops: AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, XOR 01000, SLL 01001, SRL 01010, SRA 01011, SLTU 01100, M-ops {2'b10, func3} (MUL 10000 .. REMU 10111).
REQ-018 SHALL decode alu_control 00 -> ADD, 01 -> SUB, regardless of func3/func7.
REQ-019 SHALL decode R-type func7=0000000 per func3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-020 SHALL decode R-type func7=0100000: func3 000 SUB, 101 SRA; any other func3 illegal.
REQ-021 SHALL decode R-type func7=0000001 as M-op when ENABLE_M=1, illegal when ENABLE_M=0; any other R-type func7 illegal.
REQ-022 SHALL decode I-type by func3 as REQ-019 (no SUB); func3=001 requires func7=0000000; func3=101 takes func7 0000000 SRL, 0100000 SRA, else illegal.
REQ-023 SHALL on illegal decode drive alu_con_out=00010, illegal=1, with single-cycle latency.
REQ-024 SHALL implement FSM states IDLE, STALL, HOLD.
REQ-025 SHALL accept a request on a rising edge where in_valid & in_ready & ~flush.
REQ-026 SHALL drive in_ready = ~flush & (state==IDLE | (state==HOLD & out_ready)).
REQ-027 SHALL on accept of a single-cycle op (or latency parameter = 1) register the decode and enter HOLD; out_valid high the next cycle.
REQ-028 SHALL on accept of a multi-cycle op with latency L>1 load a down-counter with L-1, enter STALL, assert busy; enter HOLD when counter reaches 0 so out_valid rises exactly L cycles after accept.
REQ-029 SHALL hold alu_con_out and illegal stable from out_valid rise until out_valid & out_ready.
REQ-030 SHALL in HOLD with out_ready: accept a new request same edge (throughput 1 op/cycle for single-cycle ops), else return to IDLE.
REQ-031 SHALL ignore in_valid in STALL; in_ready=0 in STALL.
REQ-032 SHALL on flush return to IDLE, clear out_valid, busy and counter next edge; flush has priority over accept and out_ready handshake.
REQ-033 SHALL size the counter to 6 bits; no wrap-around permitted.

Reset
REQ-034 SHALL on rst asynchronously force state IDLE, out_valid=0, busy=0, alu_con_out=00000, illegal=0, counter=0.
REQ-035 SHALL discard any in-flight op on rst mid-STALL or mid-HOLD; no result emitted after release.
REQ-036 SHALL drive in_ready=1 on the first cycle after rst deasserts (absent flush).

Verification
REQ-037 SHALL test: R-type func3=000 func7=0100000, out_ready=1 -> out_valid next cycle, alu_con_out=00110, illegal=0.
REQ-038 SHALL test: back-to-back I-type func3=111,110,011 with out_ready=1 -> outputs 00000,00001,01100 on consecutive cycles, in_ready constant 1.
REQ-039 SHALL test: R-type func7=0000001 func3=100 (DIV), DIV_LATENCY=32 -> busy high 31 cycles, out_valid exactly 32 cycles after accept, alu_con_out=10100.
REQ-040 SHALL test: ENABLE_M=0, R-type func7=0000001 -> alu_con_out=00010, illegal=1 after 1 cycle; also I-type func3=001 func7=0100000 -> illegal=1.
REQ-041 SHALL test: out_ready=0 for 5 cycles after out_valid -> output stable, in_ready=0, new in_valid not accepted.
REQ-042 SHALL test: flush at cycle 10 of a DIV, and separately rst mid-STALL -> out_valid never rises, busy=0 next cycle, in_ready=1 afterwards.
